// File: rtl/gpu_pkg.sv
// Shared definitions for the compute-unit wave sequencing logic:
// opcode encodings, the invalid wave marker and the sequencer state type.
package gpu_pkg;

    localparam logic [3:0]         OP_NOP          = 4'h0;
    localparam logic [3:0]         OP_HALT         = 4'hF;
    localparam logic signed [31:0] INVALID_WAVE_ID = -32'sd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT,
        ST_ADVANCE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/lane_mask_gen.sv
// Combinational wave geometry: global thread id of lane 0 and which lanes
// of the wave fall inside the (possibly partial) block.
module lane_mask_gen #(
    parameter int WAVE_SIZE = 32
) (
    input  logic [31:0]          num_threads,
    input  logic [31:0]          block_dim,
    input  logic signed [31:0]   core_block_id,
    input  logic signed [31:0]   wave_id,
    output logic [WAVE_SIZE-1:0] lane_mask,
    output logic [31:0]          thread_base
);

    logic [31:0] full_blocks;
    logic [31:0] rem_threads;
    logic [31:0] num_blocks;
    logic [31:0] block_threads;
    logic [31:0] wave_first;
    logic        last_block;

    assign full_blocks = num_threads / block_dim;
    assign rem_threads = num_threads % block_dim;
    assign num_blocks  = full_blocks + {31'd0, (rem_threads != 32'd0)};
    assign last_block  = ($unsigned(core_block_id) == (num_blocks - 32'd1));

    // Only a last block with a nonzero remainder is short; all others are full.
    assign block_threads = (last_block && (rem_threads != 32'd0)) ? rem_threads : block_dim;

    assign wave_first  = $unsigned(wave_id) * 32'(WAVE_SIZE);
    assign thread_base = ($unsigned(core_block_id) * block_dim) + wave_first;

    generate
        for (genvar gi = 0; gi < WAVE_SIZE; gi++) begin : g_lane
            assign lane_mask[gi] = ((wave_first + 32'(gi)) < block_threads);
        end
    endgenerate

endmodule

// File: rtl/simd_wave_sequencer.sv
// Per-SIMD wave sequencer: accepts one wave from the dispatcher, then steps
// its program through fetch / decode / lane wait until HALT or PC exhaustion.
module simd_wave_sequencer
    import gpu_pkg::*;
#(
    parameter int WAVE_SIZE = 32,
    parameter int PC_W      = 8,
    parameter int INSTR_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [31:0]          num_threads,
    input  logic [31:0]          block_dim,
    input  logic signed [31:0]   core_block_id,
    input  logic                 simd_start,
    input  logic signed [31:0]   simd_wave_id,
    output logic                 simd_done,
    output logic                 busy,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_valid,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic                 lane_issue,
    output logic [INSTR_W-1:0]   lane_instr,
    output logic [WAVE_SIZE-1:0] lane_mask,
    output logic [31:0]          thread_base,
    input  logic                 lane_done
);

    seq_state_t           state_reg;
    logic [PC_W-1:0]      pc_reg;
    logic [INSTR_W-1:0]   instr_reg;
    logic [WAVE_SIZE-1:0] mask_reg;
    logic [31:0]          base_reg;
    logic                 done_reg;
    logic                 req_reg;
    logic                 issue_reg;

    logic [WAVE_SIZE-1:0] mask_next;
    logic [31:0]          base_next;
    logic [3:0]           opcode;

    lane_mask_gen #(
        .WAVE_SIZE (WAVE_SIZE)
    ) u_lane_mask_gen (
        .num_threads   (num_threads),
        .block_dim     (block_dim),
        .core_block_id (core_block_id),
        .wave_id       (simd_wave_id),
        .lane_mask     (mask_next),
        .thread_base   (base_next)
    );

    assign opcode = instr_reg[INSTR_W-1 -: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            instr_reg <= '0;
            mask_reg  <= '0;
            base_reg  <= '0;
            done_reg  <= 1'b0;
            req_reg   <= 1'b0;
            issue_reg <= 1'b0;
        end else if (enable) begin
            issue_reg <= 1'b0;
            // Dispatcher abort: any in-progress wave is dropped, including a pending fetch.
            if (state_reg != ST_IDLE && state_reg != ST_DONE && !simd_start) begin
                state_reg <= ST_IDLE;
                req_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (simd_start && simd_wave_id != INVALID_WAVE_ID) begin
                            mask_reg  <= mask_next;
                            base_reg  <= base_next;
                            pc_reg    <= '0;
                            req_reg   <= 1'b1;
                            state_reg <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (imem_valid) begin
                            instr_reg <= imem_data;
                            req_reg   <= 1'b0;
                            state_reg <= ST_DECODE;
                        end
                    end
                    ST_DECODE: begin
                        if (opcode == OP_HALT) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else if (opcode == OP_NOP) begin
                            state_reg <= ST_ADVANCE;
                        end else begin
                            issue_reg <= 1'b1;
                            state_reg <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (lane_done) begin
                            state_reg <= ST_ADVANCE;
                        end
                    end
                    ST_ADVANCE: begin
                        // The last address acts as an implicit HALT so the PC never wraps.
                        if (pc_reg == {PC_W{1'b1}}) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            pc_reg    <= pc_reg + PC_W'(1);
                            req_reg   <= 1'b1;
                            state_reg <= ST_FETCH;
                        end
                    end
                    ST_DONE: begin
                        if (!simd_start) begin
                            done_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        req_reg   <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign simd_done   = done_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign lane_issue  = issue_reg;
    assign lane_instr  = instr_reg;
    assign lane_mask   = mask_reg;
    assign thread_base = base_reg;

endmodule
